// File: rtl/sna_request.sv
// Slave-side NoC request adapter: reassembles header/body/tail packets into AXI4-Lite
// write or read transactions and hands each response to the response packetizer.
module sna_request #(
  parameter int unsigned NUM_VC = 8,
  parameter int unsigned FLIT_W = 37
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [FLIT_W-1:0] noc_data,
  input  logic              is_valid,
  output logic [NUM_VC-1:0] is_on_off,
  output logic [NUM_VC-1:0] is_allocatable,
  output logic [31:0]       awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [31:0]       araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [31:0]       resp_data,
  output logic [1:0]        resp_code,
  output logic [2:0]        resp_vc,
  output logic              protocol_error
);

  localparam logic [1:0] FlitBody   = 2'b00;
  localparam logic [1:0] FlitTail   = 2'b01;
  localparam logic [1:0] FlitHeader = 2'b10;

  typedef enum logic [2:0] {
    StIdle, StRxBody, StRxTail, StWrAddrData, StWrResp, StRdAddr, StRdData, StHandoff
  } state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [1:0]  flit_type;
  logic [2:0]  flit_vc;
  logic [31:0] payload;

  assign flit_type = noc_data[FLIT_W-1 -: 2];
  assign flit_vc   = noc_data[FLIT_W-3 -: 3];
  assign payload   = noc_data[31:0];

  // One address register serves both channels; only one of them is ever valid.
  assign awaddr = addr_q;
  assign araddr = addr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      wdata          <= '0;
      wstrb          <= '0;
      awvalid        <= 1'b0;
      wvalid         <= 1'b0;
      bready         <= 1'b0;
      arvalid        <= 1'b0;
      rready         <= 1'b0;
      resp_valid     <= 1'b0;
      resp_write     <= 1'b0;
      resp_data      <= '0;
      resp_code      <= '0;
      resp_vc        <= '0;
      is_on_off      <= '1;
      is_allocatable <= '1;
      protocol_error <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (is_valid) begin
            if (flit_type == FlitHeader) begin
              addr_q         <= payload;
              resp_vc        <= flit_vc;
              is_on_off      <= '0;
              is_allocatable <= '0;
              state_q        <= StRxBody;
            end else begin
              protocol_error <= 1'b1;
            end
          end
        end
        StRxBody: begin
          if (is_valid) begin
            if (flit_type == FlitBody) begin
              wdata   <= payload;
              state_q <= StRxTail;
            end else if (flit_type == FlitTail) begin
              arvalid <= 1'b1;
              state_q <= StRdAddr;
            end else begin
              protocol_error <= 1'b1;
            end
          end
        end
        StRxTail: begin
          if (is_valid) begin
            if (flit_type == FlitTail) begin
              wstrb   <= payload[3:0];
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state_q <= StWrAddrData;
            end else begin
              protocol_error <= 1'b1;
            end
          end
        end
        StWrAddrData: begin
          if (is_valid) protocol_error <= 1'b1;
          if (awready) awvalid <= 1'b0;
          if (wready) wvalid <= 1'b0;
          // A channel already handshaken counts as done; both may finish on the same edge.
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready  <= 1'b1;
            state_q <= StWrResp;
          end
        end
        StWrResp: begin
          if (is_valid) protocol_error <= 1'b1;
          if (bvalid) begin
            bready     <= 1'b0;
            resp_code  <= bresp;
            resp_data  <= '0;
            resp_write <= 1'b1;
            resp_valid <= 1'b1;
            state_q    <= StHandoff;
          end
        end
        StRdAddr: begin
          if (is_valid) protocol_error <= 1'b1;
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state_q <= StRdData;
          end
        end
        StRdData: begin
          if (is_valid) protocol_error <= 1'b1;
          if (rvalid) begin
            rready     <= 1'b0;
            resp_code  <= rresp;
            resp_data  <= rdata;
            resp_write <= 1'b0;
            resp_valid <= 1'b1;
            state_q    <= StHandoff;
          end
        end
        StHandoff: begin
          if (is_valid) protocol_error <= 1'b1;
          if (resp_ready) begin
            resp_valid     <= 1'b0;
            is_on_off      <= '1;
            is_allocatable <= '1;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/sna_request.md
# sna_request

Slave-side network adapter, request path: terminates NoC request packets produced by the master-side request packetizer and replays them as AXI4-Lite write or read transactions toward the attached slave. Sits between the router's local ejection port and the slave's AXI4-Lite port. Hands each completed transaction's response to the slave-side response packetizer over a valid/ready side channel.

## Interface
- NUM_VC, 8, number of NoC virtual channels; width of the flow-control vectors
- FLIT_W, 37, flit width: [36:35] type, [34:32] VC id, [31:0] payload
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- noc_data  in  FLIT_W  ejected flit
- is_valid  in  1  noc_data valid this cycle
- is_on_off  out  NUM_VC  per-VC credit: 1 = sender may start a packet on that VC
- is_allocatable  out  NUM_VC  per-VC: 1 = VC free for a new packet
- awaddr / awvalid / awready  out/out/in  32/1/1  AXI write address
- wdata / wstrb / wvalid / wready  out/out/out/in  32/4/1/1  AXI write data
- bresp / bvalid / bready  in/in/out  2/1/1  AXI write response
- araddr / arvalid / arready  out/out/in  32/1/1  AXI read address
- rdata / rresp / rvalid / rready  in/in/in/out  32/2/1/1  AXI read data
- resp_valid / resp_ready  out/in  1/1  handoff to response packetizer
- resp_write  out  1  1 = write response, 0 = read response
- resp_data  out  32  rdata (0 for writes)
- resp_code  out  2  bresp or rresp
- resp_vc  out  3  VC id captured from the header
- protocol_error  out  1  sticky error flag, cleared only by reset

## Operation
- Flit types [36:35]: 10 header (payload = address), 00 body (payload = wdata), 01 tail (payload[3:0] = wstrb, rest ignored), 11 illegal.
- Write packet = header, body, tail. Read packet = header, tail. Command is decided by body presence.
- A flit is accepted on any cycle with is_valid=1; no stall path exists toward the router; credit is controlled by is_on_off.
- States: IDLE, RX_BODY, RX_TAIL, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, HANDOFF.
- IDLE: header -> latch addr and VC id, go RX_BODY. Body, tail, or type 11 -> drop, set protocol_error.
- RX_BODY: body -> latch wdata, go RX_TAIL. Tail -> read, go RD_ADDR. Header or type 11 -> drop, set error, stay.
- RX_TAIL: tail -> latch wstrb, go WR_ADDR_DATA. Any other type -> drop, set error, stay.
- WR_ADDR_DATA: awvalid and wvalid both asserted on entry; each deasserts independently after its own handshake; go WR_RESP once both are done (same cycle allowed).
- WR_RESP: bready=1; on bvalid latch bresp, go HANDOFF with resp_write=1, resp_data=0.
- RD_ADDR: arvalid=1 until arready, then go RD_DATA. RD_DATA: rready=1; on rvalid latch rdata/rresp, go HANDOFF with resp_write=0.
- HANDOFF: resp_valid=1; fields held stable until resp_ready, then go IDLE.
- is_on_off[v] and is_allocatable[v]: 1 for every v only in IDLE, 0 in all other states. Body/tail flits in flight are always accepted regardless of is_on_off.
- Flits arriving in AXI or HANDOFF states are dropped and set protocol_error.
- The VC id of body/tail flits is not checked.

## Timing
- Reset values: all AXI valids, bready, rready, and resp_valid = 0. is_on_off = is_allocatable = all ones. protocol_error = 0. State = IDLE. Data registers = 0.
- All outputs are registered.
- State changes take effect on the edge that samples the flit or handshake.
- is_on_off drops the cycle after the header is accepted and returns the cycle after the resp_ready handshake.
- Minimum write latency, tail accepted to resp_valid, with awready/wready/bvalid held at 1: 3 cycles (tail edge -> WR_ADDR_DATA; AW+W edge -> WR_RESP; B edge -> HANDOFF).
- Minimum read latency, tail accepted to resp_valid: 3 cycles.
- AXI rules:
  - A valid, once asserted, is never withdrawn before its ready.
  - addr/data/strb are stable while valid.
  - bready and rready are asserted only in their wait states.
- Reset asserted mid-transaction abandons the transaction immediately; outputs return to reset values on the next edge.

## Test plan
- Write packet: header 0x00031000 VC1, body 0x00000001, tail wstrb 0xF; slave readies held at 1 -> awaddr=0x00031000, wdata=1, wstrb=0xF; resp_valid 3 cycles after tail with resp_write=1, resp_code=00, resp_vc=1.
- Read packet: header 0x00000040, then tail; rdata=0xDEADBEEF, rresp=00 -> araddr=0x40; resp_data=0xDEADBEEF, resp_write=0.
- Backpressure: awready delayed 4 cycles, wready delayed 1 cycle -> awvalid holds until its handshake, wvalid drops after its own handshake, bready asserts only after both; is_on_off=0 throughout.
- Protocol errors:
  - Body flit in IDLE -> dropped, protocol_error=1, state stays IDLE.
  - Header arriving in RX_TAIL -> dropped, error stays 1, and the packet completes normally when its tail arrives.
- Handoff stall: resp_ready held 0 for 5 cycles -> resp fields stable and is_on_off=0; it returns to all ones the cycle after resp_ready=1.
- Reset issued while in WR_RESP -> next cycle: state IDLE, bready=0, is_on_off=0xFF, protocol_error=0.
